// File: rtl/piso_serializer_if.sv
// Handshake and serial-line bundle for piso_serializer.
// master = parallel producer side, slave = the serializer itself.
interface piso_serializer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              msb_first;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_start;
    logic              done;
    logic              busy;

    modport master (
        output in_valid, in_data, msb_first,
        input  in_ready, ser_out, ser_valid, frame_start, done, busy
    );

    modport slave (
        input  in_valid, in_data, msb_first,
        output in_ready, ser_out, ser_valid, frame_start, done, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with valid/ready input and DIV clocks per bit.
// Define PISO_PARITY_EN to append an even-parity bit period after the data bits.
module piso_serializer #(
    parameter int DATA_W = 8,
    parameter int DIV    = 1
) (
    input logic               clk,
    input logic               reset,
    piso_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] sreg;
    logic              msb_q;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  div_cnt;
    logic              done_q;
    logic              div_last;
    logic              bit_last;
    logic              ready;
    logic              accept;
    logic              frame_end;
    logic              ser_bit;

`ifdef PISO_PARITY_EN
    logic              par_q;

    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    assign div_last = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);
    assign accept   = bus.in_valid & ready;

    // Next state, ready and frame-end decode
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (div_last && bit_last) begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
`else
                    ready      = 1'b1;
                    frame_end  = 1'b1;
                    state_next = bus.in_valid ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (div_last) begin
                    ready      = 1'b1;
                    frame_end  = 1'b1;
                    state_next = bus.in_valid ? SHIFT : IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Shift register, counters and done strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            msb_q   <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= frame_end;
            if (accept) begin
                sreg    <= bus.in_data;
                msb_q   <= bus.msb_first;
                bit_cnt <= '0;
                div_cnt <= '0;
`ifdef PISO_PARITY_EN
                par_q   <= even_parity(bus.in_data);
`endif
            end else if (state == SHIFT) begin
                if (div_last) begin
                    div_cnt <= '0;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    sreg    <= msb_q ? {sreg[DATA_W-2:0], 1'b0} : {1'b0, sreg[DATA_W-1:1]};
                end else begin
                    div_cnt <= div_cnt + CNT_W'(1);
                end
            end
`ifdef PISO_PARITY_EN
            else if (state == PARITY) begin
                div_cnt <= div_last ? '0 : div_cnt + CNT_W'(1);
            end
`endif
            else begin
                bit_cnt <= '0;
                div_cnt <= '0;
            end
        end
    end

    always_comb begin
        ser_bit = 1'b0;
        case (state)
            SHIFT:   ser_bit = msb_q ? sreg[DATA_W-1] : sreg[0];
`ifdef PISO_PARITY_EN
            PARITY:  ser_bit = par_q;
`endif
            default: ser_bit = 1'b0;
        endcase
    end

    // in_ready is forced low while reset is held
    assign bus.in_ready    = ready & ~reset;
    assign bus.ser_out     = ser_bit;
    assign bus.ser_valid   = (state != IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.frame_start = (state == SHIFT) && (bit_cnt == '0) && (div_cnt == '0);
    assign bus.done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer at DIV=1 and DIV=3 against a per-cycle expected-output queue.
module tb_piso_serializer;

    localparam int DATA_W = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif

    logic clk = 1'b1;
    logic reset;
    logic chk_en;
    int   mode;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DV = (g == 0) ? 1 : 3;

        piso_serializer_if #(.DATA_W(DATA_W)) bus ();

        piso_serializer #(.DATA_W(DATA_W), .DIV(DV)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        // Each entry is one expected clock of line output: {bit, frame_start, last_of_frame}
        logic [2:0] q[$];
        logic       done_exp;
        logic       acc_last;

        always @(posedge clk or posedge reset) begin
            logic              acc;
            logic [2:0]        e;
            logic [DATA_W-1:0] word;
            logic              msb;
            logic              b;
            if (reset) begin
                q.delete();
                done_exp = 1'b0;
                acc_last = 1'b0;
            end else begin
                acc      = bus.in_valid && (q.size() <= 1);
                acc_last = acc;
                done_exp = 1'b0;
                if (q.size() > 0) begin
                    e        = q.pop_front();
                    done_exp = e[0];
                end
                if (acc) begin
                    word = bus.in_data;
                    msb  = bus.msb_first;
                    for (int i = 0; i < NB; i++) begin
                        if (i >= DATA_W) b = ^word;
                        else if (msb)    b = word[DATA_W-1-i];
                        else             b = word[i];
                        for (int d = 0; d < DV; d++)
                            q.push_back({b, (i == 0 && d == 0), (i == NB - 1 && d == DV - 1)});
                    end
                end
            end
        end

        always @(negedge clk) begin
            logic exp_ready;
            logic exp_out;
            logic exp_vld;
            logic exp_fs;
            exp_ready = !reset && (q.size() <= 1);
            exp_vld   = (q.size() > 0);
            exp_out   = exp_vld ? q[0][2] : 1'b0;
            exp_fs    = exp_vld ? q[0][1] : 1'b0;
            if (chk_en) begin
                check_val($sformatf("div%0d in_ready", DV),    bus.in_ready,    exp_ready);
                check_val($sformatf("div%0d ser_out", DV),     bus.ser_out,     exp_out);
                check_val($sformatf("div%0d ser_valid", DV),   bus.ser_valid,   exp_vld);
                check_val($sformatf("div%0d busy", DV),        bus.busy,        exp_vld);
                check_val($sformatf("div%0d frame_start", DV), bus.frame_start, exp_fs);
                check_val($sformatf("div%0d done", DV),        bus.done,        done_exp);
            end
            // Hold a pending word until it is taken; otherwise scramble all inputs
            if (!(bus.in_valid === 1'b1 && !acc_last)) begin
                bus.in_valid  = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
                bus.in_data   = DATA_W'($urandom);
                bus.msb_first = 1'($urandom);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        chk_en = 1'b0;
        mode   = 0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (1200) @(posedge clk);
        mode = 1;
        repeat (300) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (500) @(posedge clk);
        mode = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) mode = 1;
            repeat ($urandom_range(20, 200)) @(posedge clk);
            #3 reset = 1'b1;
            repeat (2) @(posedge clk);
            #3 reset = 1'b0;
        end
        mode = 0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
